mac_divider: RTL and testbench
==============================

# mac_divider

Sequential signed divider for the MAC datapath, performing the inverse of the feature × weight multiplier. It divides an OUT_BIT-wide signed product/accumulator value by a WEIGHT_BIT-wide signed weight and returns a FEAT_BIT-wide signed quotient plus a remainder. It uses an iterative restoring algorithm (one quotient bit per cycle) behind valid/ready handshakes on both sides. It is used for rescaling and for self-checking multiplier results in hardware.

## Interface
- FEAT_BIT, 16, quotient width (signed)
- WEIGHT_BIT, 8, divisor and remainder width (signed)
- OUT_BIT, 32, dividend width (signed); also the iteration count
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  dividend/divisor valid
- in_ready  out  1  block can accept; equals (state == IDLE)
- dividend  in  OUT_BIT  signed dividend
- divisor  in  WEIGHT_BIT  signed divisor
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- quotient  out  FEAT_BIT  signed quotient, truncated toward zero, saturated
- remainder  out  WEIGHT_BIT  signed remainder; sign follows dividend
- overflow  out  1  true quotient is outside the signed FEAT_BIT range
- div_by_zero  out  1  divisor was 0

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready:
  - latch the operand signs;
  - latch |dividend| as an OUT_BIT-bit unsigned value (-2^(OUT_BIT-1) maps to 2^(OUT_BIT-1));
  - latch |divisor|;
  - clear the counter to OUT_BIT.
  - If divisor==0, go to DONE directly; otherwise go to CALC.
- CALC: restoring step per cycle, MSB first:
  - partial = {partial, next dividend bit};
  - if partial >= |divisor|, subtract it and shift in quotient bit 1, else shift in 0;
  - decrement the counter; after OUT_BIT steps go to FIX.
- FIX:
  - Apply signs: quotient negated when the operand signs differ; remainder negated when the dividend is negative.
  - Saturate: a quotient above 2^(FEAT_BIT-1)-1 gives 2^(FEAT_BIT-1)-1; below -2^(FEAT_BIT-1) gives -2^(FEAT_BIT-1). Either case sets overflow=1 and remainder=0.
  - Register outputs, go to DONE.
- Div-by-zero result:
  - quotient = 2^(FEAT_BIT-1)-1 if dividend >= 0, else -2^(FEAT_BIT-1);
  - remainder=0, div_by_zero=1, overflow=0.
- DONE: out_valid=1. Outputs and flags are held stable until out_valid&&out_ready, then go to IDLE. in_ready=0 here; there is no overlap of operations.
- Arithmetic rules: results match SV signed `/` and `%` for all non-overflow, nonzero-divisor cases. |remainder| < |divisor| <= 2^(WEIGHT_BIT-1), so the remainder always fits. A quotient of exactly -2^(FEAT_BIT-1) is not an overflow.
- Operand inputs are ignored outside the IDLE accept edge. Changing them mid-operation has no effect.

## Timing
- Reset (asynchronous, any state): state=IDLE, out_valid=0, quotient=0, remainder=0, overflow=0, div_by_zero=0, counter=0.
  - in_ready=1 once state is IDLE; inputs are not sampled while rst_n=0.
  - Reset mid-CALC/FIX/DONE aborts the operation; no result is ever presented.
- Latency, normal case: accept edge E0; out_valid is high after edge E0+OUT_BIT+1 (33 edges at defaults).
- Latency, divide-by-zero: out_valid is high after edge E0 (next cycle).
- out_valid falls and in_ready rises after the out_ready handshake edge. The earliest next accept is the following edge, so throughput is 1 operation per OUT_BIT+3 cycles at best.
- out_valid held indefinitely under out_ready=0; out_ready while out_valid=0 is ignored.

## Test plan
- dividend=-32512, divisor=127 (inverse of -256 × 127) -> quotient=-256, remainder=0, overflow=0, out_valid exactly 33 edges after accept.
- 7/-2 -> q=-3, r=1; -7/2 -> q=-3, r=-1; -7/-2 -> q=3, r=-1; -32768/1 -> q=-32768, overflow=0.
- 32'h7FFFFFFF/1 -> q=32767, r=0, overflow=1; 32'h80000000/-1 -> q=32767, overflow=1; 32'h80000000/1 -> q=-32768, overflow=1.
- 1000/0 -> q=32767, div_by_zero=1, out_valid one cycle after accept; -5/0 -> q=-32768, div_by_zero=1.
- Backpressure: hold out_ready=0 for 10 cycles -> outputs stable, in_ready=0, new in_valid not accepted; out_ready=1 -> in_ready=1 the next cycle.
- Reset pulse at CALC step 10 -> out_valid=0, all outputs 0, in_ready=1. A fresh 100/7 afterwards -> q=14, r=2.

Source files
------------

// File: rtl/mac_divider.sv
// mac_divider: sequential signed divider for the MAC datapath.
// It divides a signed OUT_BIT-wide dividend by a signed WEIGHT_BIT-wide divisor.
// The result is a signed FEAT_BIT quotient, truncated toward zero and saturated,
// plus a signed WEIGHT_BIT remainder whose sign follows the dividend.
// A restoring algorithm produces one quotient bit per cycle.
//
// Handshakes (both sides):
//   A transfer happens on a rising edge where valid && ready.
//   The input side is ready only in IDLE. Operands are sampled only on the
//   accept edge. The output side holds out_valid and all result fields stable
//   until the consumer takes them with out_ready.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready == state IDLE)
//   dividend, divisor     signed operands
//   out_valid / out_ready result handshake (out_valid == state DONE)
//   quotient, remainder   signed results
//   overflow              true quotient did not fit in FEAT_BIT
//   div_by_zero           divisor was zero
//   o_dbg_state           current FSM state, for observation
module mac_divider #(
  parameter int FEAT_BIT   = 16,
  parameter int WEIGHT_BIT = 8,
  parameter int OUT_BIT    = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OUT_BIT-1:0]    dividend,
  input  logic [WEIGHT_BIT-1:0] divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [FEAT_BIT-1:0]   quotient,
  output logic [WEIGHT_BIT-1:0] remainder,
  output logic                  overflow,
  output logic                  div_by_zero,
  output logic [1:0]            o_dbg_state
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam int CW = $clog2(OUT_BIT + 1);

  localparam logic [FEAT_BIT-1:0] Q_MAX = {1'b0, {(FEAT_BIT-1){1'b1}}};
  localparam logic [FEAT_BIT-1:0] Q_MIN = {1'b1, {(FEAT_BIT-1){1'b0}}};
  // Largest quotient magnitudes representable for each result sign.
  localparam logic [OUT_BIT-1:0] MAG_POS_LIM =
    {{(OUT_BIT-FEAT_BIT+1){1'b0}}, {(FEAT_BIT-1){1'b1}}};
  localparam logic [OUT_BIT-1:0] MAG_NEG_LIM = MAG_POS_LIM + OUT_BIT'(1);

  logic [1:0]            r_state;
  logic [CW-1:0]         r_cnt;
  // r_dvd shifts dividend bits out of the top and quotient bits in at the bottom.
  // After OUT_BIT steps it holds the quotient magnitude.
  logic [OUT_BIT-1:0]    r_dvd;
  logic [WEIGHT_BIT-1:0] r_part;
  logic [WEIGHT_BIT-1:0] r_dsr;
  logic                  r_q_neg;
  logic                  r_dvd_neg;
  logic [FEAT_BIT-1:0]   r_quotient;
  logic [WEIGHT_BIT-1:0] r_remainder;
  logic                  r_overflow;
  logic                  r_div_by_zero;

  logic [OUT_BIT-1:0]    w_dvd_abs;
  logic [WEIGHT_BIT-1:0] w_dsr_abs;
  logic [WEIGHT_BIT:0]   w_shift;
  logic [WEIGHT_BIT:0]   w_diff;
  logic                  w_ge;
  logic                  w_ovf;
  logic [FEAT_BIT-1:0]   w_q_signed;
  logic [WEIGHT_BIT-1:0] w_r_signed;
  logic                  w_unused;

  // Unsigned magnitudes. The most negative value maps to 2^(N-1), which still
  // fits in the unsigned N-bit field.
  assign w_dvd_abs = dividend[OUT_BIT-1] ? (OUT_BIT'(0) - dividend) : dividend;
  assign w_dsr_abs = divisor[WEIGHT_BIT-1] ? (WEIGHT_BIT'(0) - divisor) : divisor;

  // The partial remainder stays below |divisor| <= 2^(WEIGHT_BIT-1).
  // One extra bit therefore covers the shifted value.
  assign w_shift = {r_part, r_dvd[OUT_BIT-1]};
  assign w_ge    = (w_shift >= {1'b0, r_dsr});
  assign w_diff  = w_shift - {1'b0, r_dsr};
  // After a subtraction the difference is below |divisor|, so its top bit is always 0.
  assign w_unused = w_diff[WEIGHT_BIT];

  assign w_ovf      = r_q_neg ? (r_dvd > MAG_NEG_LIM) : (r_dvd > MAG_POS_LIM);
  assign w_q_signed = r_q_neg ? (FEAT_BIT'(0) - r_dvd[FEAT_BIT-1:0]) : r_dvd[FEAT_BIT-1:0];
  assign w_r_signed = r_dvd_neg ? (WEIGHT_BIT'(0) - r_part) : r_part;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_dvd         <= '0;
      r_part        <= '0;
      r_dsr         <= '0;
      r_q_neg       <= 1'b0;
      r_dvd_neg     <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_overflow    <= 1'b0;
      r_div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_q_neg   <= dividend[OUT_BIT-1] ^ divisor[WEIGHT_BIT-1];
            r_dvd_neg <= dividend[OUT_BIT-1];
            r_dvd     <= w_dvd_abs;
            r_dsr     <= w_dsr_abs;
            r_part    <= '0;
            r_cnt     <= CW'(OUT_BIT);
            if (divisor == '0) begin
              r_quotient    <= dividend[OUT_BIT-1] ? Q_MIN : Q_MAX;
              r_remainder   <= '0;
              r_overflow    <= 1'b0;
              r_div_by_zero <= 1'b1;
              r_state       <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_part <= w_ge ? w_diff[WEIGHT_BIT-1:0] : w_shift[WEIGHT_BIT-1:0];
          r_dvd  <= {r_dvd[OUT_BIT-2:0], w_ge};
          r_cnt  <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) r_state <= S_FIX;
        end
        S_FIX: begin
          r_div_by_zero <= 1'b0;
          r_overflow    <= w_ovf;
          if (w_ovf) begin
            r_quotient  <= r_q_neg ? Q_MIN : Q_MAX;
            r_remainder <= '0;
          end else begin
            r_quotient  <= w_q_signed;
            r_remainder <= w_r_signed;
          end
          r_state <= S_DONE;
        end
        default: begin
          if (out_ready) r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign quotient    = r_quotient;
  assign remainder   = r_remainder;
  assign overflow    = r_overflow;
  assign div_by_zero = r_div_by_zero;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mac_divider.sv
module tb_mac_divider;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        overflow;
  logic        div_by_zero;
  logic [1:0]  dbg_state;

  int n_vec;
  int n_err;

  mac_divider dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .overflow    (overflow),
    .div_by_zero (div_by_zero),
    .o_dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present operands at a negedge. Return just after the accept edge E0.
  // The operand inputs are then scrambled to show they are no longer sampled.
  task automatic start_op(input logic [31:0] a, input logic [7:0] b);
    @(negedge clk);
    check("in_ready_before_accept", int'(in_ready), 1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = 8'($urandom_range(1, 255));
  endtask

  // Count the edges after E0 until out_valid is seen. The wait is bounded.
  task automatic wait_out(input string tag, input int exp_lat);
    int lat;
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({tag, "_out_valid"}, int'(out_valid), 1);
    check({tag, "_latency"}, lat, exp_lat);
  endtask

  task automatic check_out(input string tag, input int q, input int r,
                           input int ovf, input int dbz);
    check({tag, "_q"},   int'($signed(quotient)), q);
    check({tag, "_r"},   int'($signed(remainder)), r);
    check({tag, "_ovf"}, int'(overflow), ovf);
    check({tag, "_dbz"}, int'(div_by_zero), dbz);
  endtask

  // Take the result at a negedge. The next negedge must show IDLE again.
  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_valid_drop"}, int'(out_valid), 0);
    check({tag, "_ready_rise"}, int'(in_ready), 1);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [7:0] b,
                        input int q, input int r, input int ovf, input int dbz,
                        input int lat);
    start_op(a, b);
    wait_out(tag, lat);
    check_out(tag, q, r, ovf, dbz);
    release_out(tag);
  endtask

  // Hold the result under backpressure while an unwanted request is offered.
  task automatic backpressure_test();
    start_op(32'd50, 8'd5);
    wait_out("bp", 33);
    dividend = 32'd9;
    divisor  = 8'd3;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      @(negedge clk);
      check("bp_hold_valid", int'(out_valid), 1);
      check("bp_hold_in_ready", int'(in_ready), 0);
      check("bp_hold_q", int'($signed(quotient)), 10);
      check("bp_hold_r", int'($signed(remainder)), 0);
    end
    in_valid = 1'b0;
    check_out("bp", 10, 0, 0, 0);
    release_out("bp");
    @(negedge clk);
    check("bp_stays_idle", int'(dbg_state), 0);
  endtask

  task automatic reset_mid_calc();
    start_op(32'd12345, 8'd3);
    repeat (9) @(posedge clk);
    @(negedge clk);
    check("rst_mid_state_calc", int'(dbg_state), 1);
    rst_n = 1'b0;
    #2;
    check("rst_mid_valid", int'(out_valid), 0);
    check("rst_mid_in_ready", int'(in_ready), 1);
    check("rst_mid_q", int'(quotient), 0);
    check("rst_mid_r", int'(remainder), 0);
    check("rst_mid_ovf", int'(overflow), 0);
    check("rst_mid_dbz", int'(div_by_zero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge clk);
      check("rst_no_result", int'(out_valid), 0);
    end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    check("reset_valid", int'(out_valid), 0);
    check("reset_in_ready", int'(in_ready), 1);
    check("reset_q", int'(quotient), 0);
    check("reset_r", int'(remainder), 0);
    check("reset_ovf", int'(overflow), 0);
    check("reset_dbz", int'(div_by_zero), 0);
    check("reset_state", int'(dbg_state), 0);
    rst_n = 1'b1;
    @(negedge clk);
    // out_ready while out_valid is low is ignored.
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("idle_ignore_out_ready", int'(dbg_state), 0);

    run_op("inv_mul",   -32'sd32512, 8'sd127,   -256,   0, 0, 0, 33);
    run_op("p7_m2",     32'sd7,      -8'sd2,    -3,     1, 0, 0, 33);
    run_op("m7_p2",     -32'sd7,     8'sd2,     -3,    -1, 0, 0, 33);
    run_op("m7_m2",     -32'sd7,     -8'sd2,     3,    -1, 0, 0, 33);
    run_op("qmin_ok",   -32'sd32768, 8'sd1,     -32768, 0, 0, 0, 33);
    run_op("big_dsr",   32'sd1000,   -8'sd128,  -7,   104, 0, 0, 33);
    run_op("neg_big",   -32'sd1000,  -8'sd128,   7,  -104, 0, 0, 33);
    run_op("max_div1",  32'h7FFF_FFFF, 8'sd1,    32767, 0, 1, 0, 33);
    run_op("min_divm1", 32'h8000_0000, -8'sd1,   32767, 0, 1, 0, 33);
    run_op("min_div1",  32'h8000_0000, 8'sd1,   -32768, 0, 1, 0, 33);
    run_op("dbz_pos",   32'sd1000,   8'sd0,      32767, 0, 0, 1, 0);
    run_op("dbz_neg",   -32'sd5,     8'sd0,     -32768, 0, 0, 1, 0);
    // A normal result after a divide-by-zero must clear the flag.
    run_op("after_dbz", 32'sd9,      8'sd4,      2,     1, 0, 0, 33);

    backpressure_test();
    reset_mid_calc();
    run_op("post_rst",  32'sd100,    8'sd7,      14,    2, 0, 0, 33);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
